// File: rtl/bg_mem_arbiter.sv
// bg_mem_arbiter
// Owns the single port of the 160x120x12 background frame buffer. Display
// reads win every pixel slot that falls inside the active area; a one-entry
// write buffer fed by game logic and an optional fill engine share the rest.
// The display path is 4x upscaled (640x480 active) and returns pixels on a
// fixed two-cycle pipeline.
// Build option: define BG_CLEAR_EN to compile in the full-screen fill engine.
// Without it clear_start/clear_color are ignored and clear_busy stays low.

module bg_mem_arbiter (
  input  logic        clk,
  input  logic        rst,          // synchronous, active-low
  input  logic        pix_en,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [11:0] pixel,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_data,
  output logic        wr_err,
  input  logic        clear_start,
  input  logic [11:0] clear_color,
  output logic        clear_busy,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_din,
  input  logic [11:0] mem_dout
);

  localparam logic [9:0]  H_ACTIVE  = 10'd640;
  localparam logic [9:0]  V_ACTIVE  = 10'd480;
  localparam logic [7:0]  SRC_W     = 8'd160;
  localparam logic [6:0]  SRC_H     = 7'd120;
  localparam logic [14:0] ROW_PITCH = 15'd160;
  localparam logic [14:0] LAST_WORD = 15'd19199;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Fill engine state
  state_t      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic [11:0] clr_color_q, clr_color_d;

  // One-entry write buffer
  logic        buf_full_q, buf_full_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic [11:0] buf_data_q, buf_data_d;
  logic        wr_err_q, wr_err_d;

  // Display return pipeline: remembers whether last cycle was a pixel slot
  // and whether that slot actually read the BRAM.
  logic        rd_slot_q, rd_slot_d;
  logic        rd_active_q, rd_active_d;
  logic [11:0] pixel_q, pixel_d;

  // Grant and address helpers
  logic        disp_active;
  logic        disp_grant;
  logic        wr_grant;
  logic        clr_grant;
  logic        in_clear;
  logic        wr_accept;
  logic        wr_in_range;
  logic [14:0] disp_addr;
  logic [14:0] wr_addr;

  assign in_clear   = (state_q == ST_CLEAR);
  assign clear_busy = in_clear;
  assign wr_ready   = !buf_full_q && !in_clear;
  assign wr_err     = wr_err_q;
  assign pixel      = pixel_q;

  // Per-cycle grant: display slot, then buffered write, then fill word
  always_comb begin
    disp_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    // Out-of-range counters may wrap here; the address is only used when active.
    disp_addr   = 15'(h_cnt[9:2]) + 15'(v_cnt[9:2]) * ROW_PITCH;
    disp_grant  = pix_en && disp_active;
    wr_grant    = !disp_grant && buf_full_q;
    clr_grant   = !disp_grant && !buf_full_q && in_clear;

    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (disp_grant) begin
      mem_addr = disp_addr;
    end else if (wr_grant) begin
      mem_addr = buf_addr_q;
      mem_we   = 1'b1;
      mem_din  = buf_data_q;
    end else if (clr_grant) begin
      mem_addr = clr_cnt_q;
      mem_we   = 1'b1;
      mem_din  = clr_color_q;
    end
  end

  // Write buffer: accept, range-check, and drain on its grant
  always_comb begin
    wr_accept   = wr_valid && wr_ready;
    wr_in_range = (wr_x < SRC_W) && (wr_y < SRC_H);
    wr_addr     = 15'(wr_y) * ROW_PITCH + 15'(wr_x);

    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    wr_err_d   = 1'b0;

    if (wr_grant) begin
      buf_full_d = 1'b0;
    end
    // wr_ready is low while full, so an accept never collides with a drain.
    if (wr_accept) begin
      if (wr_in_range) begin
        buf_full_d = 1'b1;
        buf_addr_d = wr_addr;
        buf_data_d = wr_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

`ifdef BG_CLEAR_EN
  // Fill engine next state: walk every word once, then fall back to idle
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end
      end
      ST_CLEAR: begin
        // A second clear_start while filling is deliberately ignored.
        if (clr_grant) begin
          if (clr_cnt_q == LAST_WORD) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 15'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end
`else
  logic unused_clear_inputs;
  assign unused_clear_inputs = clear_start ^ (^clear_color);

  // No fill engine: the state machine is pinned to idle
  always_comb begin
    state_d     = ST_IDLE;
    clr_cnt_d   = '0;
    clr_color_d = '0;
  end
`endif

  // Display return: a slot's data lands one cycle later; blanking slots load black
  always_comb begin
    rd_slot_d   = pix_en;
    rd_active_d = disp_active;
    pixel_d     = pixel_q;
    if (rd_slot_q) begin
      pixel_d = rd_active_q ? mem_dout : 12'h000;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      wr_err_q    <= 1'b0;
      rd_slot_q   <= 1'b0;
      rd_active_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      wr_err_q    <= wr_err_d;
      rd_slot_q   <= rd_slot_d;
      rd_active_q <= rd_active_d;
      pixel_q     <= pixel_d;
    end
  end

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Testbench for bg_mem_arbiter: a BRAM model on the memory port, a
// priority/queue reference model checked every cycle, directed literal
// scenarios, then randomized traffic with occasional resets.

module tb_bg_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [11:0] pixel;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic        wr_err;
  logic        clear_start = 1'b0;
  logic [11:0] clear_color = '0;
  logic        clear_busy;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_din;
  logic [11:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;

  bg_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .pixel       (pixel),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  // Initial BRAM content is a fixed address pattern so display reads are nonzero.
  function automatic logic [11:0] pat(input int a);
    return 12'(a * 97 + 965);
  endfunction

  // BRAM: stores value XOR pattern, so all-zero storage means "pattern content".
  bit [11:0] stored [0:32767];
  always @(posedge clk) begin
    if (mem_we) stored[mem_addr] <= mem_din ^ pat(int'(mem_addr));
    mem_dout <= stored[mem_addr] ^ pat(int'(mem_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          a;
    logic [11:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [11:0] image [0:32767];
  bit          m_clearing = 1'b0;
  int          m_clr_next = 0;
  logic [11:0] m_color = '0;
  bit          m_err = 1'b0;
  logic [11:0] m_pix = '0;
  bit          m_pend = 1'b0;
  logic [11:0] m_pend_val = '0;

  initial begin
    for (int i = 0; i < 32768; i++) image[i] = pat(i);
  end

  task automatic model_cycle();
    bit          act;
    bit          ewe;
    bit          erdy;
    bit          was_clearing;
    int          da;
    int          ea;
    int          kind;
    logic [11:0] ed;
    wr_t         e;

    act  = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    da   = (int'(h_cnt) / 4) + 160 * (int'(v_cnt) / 4);
    kind = 0; ea = 0; ed = '0; ewe = 1'b0;
    if (pix_en && act) begin
      kind = 1; ea = da;
    end else if (wq.size() > 0) begin
      kind = 2; ea = wq[0].a; ed = wq[0].d; ewe = 1'b1;
    end else if (m_clearing) begin
      kind = 3; ea = m_clr_next; ed = m_color; ewe = 1'b1;
    end
    erdy = (wq.size() == 0) && !m_clearing;

    check("mem_addr",   32'(mem_addr),   32'(ea));
    check("mem_we",     32'(mem_we),     32'(ewe));
    check("mem_din",    32'(mem_din),    32'(ed));
    check("wr_ready",   32'(wr_ready),   32'(erdy));
    check("wr_err",     32'(wr_err),     32'(m_err));
    check("pixel",      32'(pixel),      32'(m_pix));
    check("clear_busy", 32'(clear_busy), 32'(m_clearing));

    if (ewe) image[ea] = ed;

    if (!rst) begin
      wq.delete();
      m_clearing = 1'b0; m_clr_next = 0; m_color = '0;
      m_err = 1'b0; m_pix = '0; m_pend = 1'b0; m_pend_val = '0;
    end else begin
      was_clearing = m_clearing;
      if (m_pend) m_pix = m_pend_val;
      m_pend     = pix_en;
      m_pend_val = act ? image[da] : 12'h000;
      if (kind == 2) void'(wq.pop_front());
      if (kind == 3) begin
        if (m_clr_next == 19199) m_clearing = 1'b0;
        else m_clr_next++;
      end
      m_err = 1'b0;
      if (wr_valid && erdy) begin
        if (wr_x < 8'd160 && wr_y < 7'd120) begin
          e.a = int'(wr_y) * 160 + int'(wr_x);
          e.d = wr_data;
          wq.push_back(e);
        end else begin
          m_err = 1'b1;
        end
      end
`ifdef BG_CLEAR_EN
      if (!was_clearing && clear_start) begin
        m_clearing = 1'b1; m_clr_next = 0; m_color = clear_color;
      end
`else
      if (was_clearing) m_clearing = 1'b0;
`endif
    end
  endtask

  // Compare process: every cycle, mid-cycle
  always @(negedge clk) model_cycle();

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  bad;
    int  cyc;
    bit  done;

    // Reset held for three cycles
    rst = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_pixel",      32'(pixel),      32'h0);
    check("rst_clear_busy", 32'(clear_busy), 32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);

    // Seed address 162 (x=2, y=1) with 0xABC through the write port
    tick(); wr_valid = 1'b1; wr_x = 8'd2; wr_y = 7'd1; wr_data = 12'hABC;
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    check("seed_we",   32'(mem_we),   32'h1);
    check("seed_addr", 32'(mem_addr), 32'd162);
    tick(); tick();

    // Display read at h=8, v=4
    tick(); pix_en = 1'b1; h_cnt = 10'd8; v_cnt = 10'd4;
    @(negedge clk);
    check("disp_addr", 32'(mem_addr), 32'd162);
    check("disp_we",   32'(mem_we),   32'h0);
    tick(); pix_en = 1'b0;
    tick();
    @(negedge clk);
    check("disp_pixel", 32'(pixel), 32'hABC);

    // Write vs display conflict
    tick(); wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd2; wr_data = 12'h0F0;
    @(negedge clk);
    check("conf_ready_T", 32'(wr_ready), 32'h1);
    tick(); wr_valid = 1'b0; pix_en = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0;
    @(negedge clk);
    check("conf_we_T1",    32'(mem_we),   32'h0);
    check("conf_ready_T1", 32'(wr_ready), 32'h0);
    tick(); pix_en = 1'b0;
    @(negedge clk);
    check("conf_we_T2",    32'(mem_we),   32'h1);
    check("conf_addr_T2",  32'(mem_addr), 32'd325);
    check("conf_din_T2",   32'(mem_din),  32'h0F0);
    check("conf_ready_T2", 32'(wr_ready), 32'h0);
    tick();
    @(negedge clk);
    check("conf_ready_T3", 32'(wr_ready), 32'h1);

    // Out-of-range write
    tick(); wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_data = 12'h123;
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    check("oor_err_T1", 32'(wr_err), 32'h1);
    check("oor_we_T1",  32'(mem_we), 32'h0);
    tick();
    @(negedge clk);
    check("oor_err_T2", 32'(wr_err), 32'h0);
    check("oor_we_T2",  32'(mem_we), 32'h0);

    // Blanking slot after a read of address 0 (pattern 0x3C5) left pixel nonzero
    tick(); pix_en = 1'b1; h_cnt = 10'd700; v_cnt = 10'd0;
    @(negedge clk);
    check("blank_we",   32'(mem_we),   32'h0);
    check("blank_addr", 32'(mem_addr), 32'h0);
    tick(); pix_en = 1'b0;
    tick();
    @(negedge clk);
    check("blank_pixel", 32'(pixel), 32'h0);

`ifdef BG_CLEAR_EN
    // Full clear with a write accepted in the same cycle as clear_start
    tick(); clear_start = 1'b1; clear_color = 12'h00F;
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd0; wr_data = 12'hFFF;
    tick(); clear_start = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("clr_busy_start", 32'(clear_busy), 32'h1);
    done = 1'b0;
    for (cyc = 0; cyc < 30000; cyc++) begin
      tick();
      pix_en = (cyc % 4 == 0);
      h_cnt  = 10'($urandom_range(0, 639));
      v_cnt  = 10'($urandom_range(0, 479));
      @(negedge clk);
      if (!clear_busy) begin
        done = 1'b1;
        break;
      end
    end
    pix_en = 1'b0;
    check("clr_finished", 32'(done), 32'h1);
    check("clr_cycles_ok", 32'(cyc <= 25601), 32'h1);
    bad = 0;
    for (int i = 0; i < 19200; i++)
      if ((stored[i] ^ pat(i)) != 12'h00F) bad++;
    check("clr_bad_words", 32'(bad), 32'h0);

    // Reset in the middle of a clear
    tick(); clear_start = 1'b1; clear_color = 12'h7A1;
    tick(); clear_start = 1'b0;
    repeat (50) tick();
    rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check("clr_rst_busy", 32'(clear_busy), 32'h0);
`else
    // No fill engine: clear_start has no effect
    tick(); clear_start = 1'b1; clear_color = 12'h00F;
    tick(); clear_start = 1'b0;
    @(negedge clk);
    check("noclr_busy",  32'(clear_busy), 32'h0);
    check("noclr_ready", 32'(wr_ready),   32'h1);
`endif

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst      = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      pix_en   = (c % 4 == 0);
      h_cnt    = 10'($urandom_range(0, 799));
      v_cnt    = 10'($urandom_range(0, 524));
      wr_valid = 1'($urandom_range(0, 1));
      wr_x     = 8'($urandom_range(0, 165));
      wr_y     = 7'($urandom_range(0, 125));
      wr_data  = 12'($urandom);
    end
    tick(); rst = 1'b1; wr_valid = 1'b0; pix_en = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
